// File: rtl/train_crossing_pkg.sv
// Shared types and constants for the multi-track level-crossing controller.
package train_crossing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARN   = 3'd1,
    ST_CLOSED = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam int DEF_N_TRACKS          = 2;
  localparam int DEF_WARN_CYCLES       = 8;
  localparam int DEF_CLEAR_HOLD_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES    = 1024;

  // Wide enough to hold the longest phase length without wrapping.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/train_crossing_mt_timer.sv
// Clear/enable saturating up-counter with a terminal-count compare.
module crossing_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             hit_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = (count_q == term_i);

endmodule

// File: rtl/train_crossing_mt.sv
// Multi-track crossing controller: per-track occupancy, warn/close/hold sequencing
// and a latched timeout fault. All outputs decode the registered state.
module train_crossing_mt
  import train_crossing_pkg::*;
#(
  parameter int N_TRACKS          = DEF_N_TRACKS,
  parameter int WARN_CYCLES       = DEF_WARN_CYCLES,
  parameter int CLEAR_HOLD_CYCLES = DEF_CLEAR_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TRACKS-1:0] train_sensor,
  input  logic [N_TRACKS-1:0] train_clear,
  output logic                gate,
  output logic                warn_light,
  output logic [N_TRACKS-1:0] occupied,
  output logic                fault,
  output logic [2:0]          state_dbg
);

  localparam int TW = timer_width(WARN_CYCLES, CLEAR_HOLD_CYCLES, TIMEOUT_CYCLES);
  // The timer reads 0 on the first cycle of a state, so term = length - 1.
  localparam logic [TW-1:0] WARN_TERM    = TW'(WARN_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_TERM    = TW'(CLEAR_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_TERM = TW'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  state_e              state_d;
  logic [N_TRACKS-1:0] occ_q;
  logic [N_TRACKS-1:0] occ_d;
  logic                any_sensor;
  logic                all_clear;
  logic                timer_clr;
  logic                timer_en;
  logic                timer_hit;
  logic [TW-1:0]       timer_term;

  // Sensor beats clear on the same track in the same cycle.
  assign occ_d      = train_sensor | (occ_q & ~train_clear);
  assign any_sensor = |train_sensor;
  assign all_clear  = (occ_d == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_sensor) state_d = ST_WARN;
      ST_WARN:   if (timer_hit) state_d = ST_CLOSED;
      ST_CLOSED: begin
        if (all_clear) state_d = ST_HOLD;
        else if (timer_hit) state_d = ST_FAULT;
      end
      ST_HOLD: begin
        if (any_sensor) state_d = ST_CLOSED;
        else if (timer_hit) state_d = ST_IDLE;
      end
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_term = '0;
    case (state_q)
      ST_WARN:   timer_term = WARN_TERM;
      ST_CLOSED: timer_term = TIMEOUT_TERM;
      ST_HOLD:   timer_term = HOLD_TERM;
      default:   timer_term = '0;
    endcase
  end

  assign timer_clr = (state_d != state_q);
  assign timer_en  = (state_q != ST_IDLE);

  crossing_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .term_i (timer_term),
    .hit_o  (timer_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
    end
  end

  assign warn_light = (state_q != ST_IDLE);
  assign gate       = (state_q == ST_CLOSED) || (state_q == ST_HOLD) || (state_q == ST_FAULT);
  assign fault      = (state_q == ST_FAULT);
  assign occupied   = occ_q;
  assign state_dbg  = state_q;

endmodule
